// File: rtl/hex_display_pkg.sv
// hex_display_pkg: register map and hex-to-segment table shared by the hex display PIO.
package hex_display_pkg;
  typedef enum logic [3:0] {
    A_DATA   = 4'd0,
    A_RAW_EN = 4'd1,
    A_BLINK  = 4'd2,
    A_BLANK  = 4'd3,
    A_STATUS = 4'd4,
    A_RAW    = 4'd8
  } reg_addr_e;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_SEG[n];
  endfunction
endpackage

// File: rtl/hex_display_pio_if.sv
// hex_display_pio_if: Avalon-MM slave bus of the hex display PIO.
interface hex_display_pio_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational nibble to lit 7-segment pattern (bit 0 = segment a).
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_seg(nibble);
endmodule

// File: rtl/hex_display_pio.sv
// hex_display_pio: memory-mapped multi-digit 7-segment driver with raw override, blink and blank.
module hex_display_pio
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  hex_display_pio_if.slave          bus,
  output logic [7*NUM_DIGITS-1:0]   out_port
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [6:0] POL = ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   raw_en, blink, blank;
  logic [6:0]              raw [NUM_DIGITS];
  logic [6:0]              dec [NUM_DIGITS];
  logic [CW-1:0]           cnt;
  logic                    phase;
  logic [31:0]             rd_val;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    wr, rd;
  logic                    unused_bits;
  assign wr = bus.chipselect && !bus.write_n;
  assign rd = bus.chipselect && !bus.read_n;
  assign unused_bits = ^bus.writedata;
  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= '0;
      raw_en <= '0;
      blink  <= '0;
      blank  <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) raw[k] <= '0;
    end else if (wr) begin
      if (bus.address == A_DATA)   data   <= bus.writedata[4*NUM_DIGITS-1:0];
      if (bus.address == A_RAW_EN) raw_en <= bus.writedata[NUM_DIGITS-1:0];
      if (bus.address == A_BLINK)  blink  <= bus.writedata[NUM_DIGITS-1:0];
      if (bus.address == A_BLANK)  blank  <= bus.writedata[NUM_DIGITS-1:0];
      for (int k = 0; k < NUM_DIGITS; k++)
        if (bus.address[3] && bus.address[2:0] == 3'(k)) raw[k] <= bus.writedata[6:0];
    end
  end
  // Phase flips on the wrap cycle; writes never disturb the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
  always_comb begin
    rd_val = '0;
    if (bus.address == A_DATA)        rd_val = 32'(data);
    else if (bus.address == A_RAW_EN) rd_val = 32'(raw_en);
    else if (bus.address == A_BLINK)  rd_val = 32'(blink);
    else if (bus.address == A_BLANK)  rd_val = 32'(blank);
    else if (bus.address == A_STATUS) rd_val = 32'(phase);
    else
      for (int k = 0; k < NUM_DIGITS; k++)
        if (bus.address[3] && bus.address[2:0] == 3'(k)) rd_val = 32'(raw[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else if (rd) bus.readdata <= rd_val;
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] lit;
    logic       dark;
    hex7seg_decode u_dec (.nibble(data[4*g +: 4]), .seg(dec[g]));
    assign lit  = raw_en[g] ? raw[g] : dec[g];
    assign dark = blank[g] || (blink[g] && !phase);
    assign seg_next[7*g +: 7] = (dark ? 7'h00 : lit) ^ POL;
  end
  always_ff @(posedge clk) begin
    if (reset) out_port <= {NUM_DIGITS{hex_seg(4'h0) ^ POL}};
    else out_port <= seg_next;
  end
endmodule

// File: tb/tb_hex_display_pio.sv
// tb_hex_display_pio: directed self-checking bench for hex_display_pio (3 digits, active-low, BLINK_DIV=4).
module tb_hex_display_pio;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [20:0] out_port;
  int vectors = 0;
  int errs = 0;
  hex_display_pio_if bus ();
  hex_display_pio #(.NUM_DIGITS(3), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .out_port(out_port)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [3:0] a);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = a;
    tick();
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask
  logic [3:0]  rd_addr [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd5, 4'd15};
  logic [31:0] rd_exp  [10] = '{32'hA5F, 32'h2, 32'h1, 32'h1, 32'h7F, 32'h49, 32'h0, 32'h0, 32'h0, 32'h0};
  initial begin
    logic prev;
    int   n;
    logic lit;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    bus.address = '0; bus.writedata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_out", 32'(out_port), 32'h102040);
    chk("reset_readdata", bus.readdata, 32'h0);
    rd(4'd0);
    chk("reset_data", bus.readdata, 32'h0);
    wr(4'd0, 32'h0000_0A5F);
    chk("out_latency", 32'(out_port), 32'h102040);
    tick();
    chk("out_data", 32'(out_port), 32'h2090E);
    rd(4'd0);
    chk("read_data", bus.readdata, 32'hA5F);
    wr(4'd1, 32'h2);
    wr(4'd9, 32'h49);
    wr(4'd8, 32'hFFFF_FFFF);
    tick();
    chk("out_raw", 32'(out_port), 32'h21B0E);
    rd(4'd9);
    chk("read_raw9", bus.readdata, 32'h49);
    tick();
    chk("readdata_hold", bus.readdata, 32'h49);
    rd(4'd8);
    chk("read_raw8_width", bus.readdata, 32'h7F);
    bus.read_n = 1'b0;
    wr(4'd0, 32'h321);
    bus.read_n = 1'b1;
    chk("rw_same_cycle", bus.readdata, 32'hA5F);
    rd(4'd0);
    chk("read_after_rw", bus.readdata, 32'h321);
    wr(4'd0, 32'hA5F);
    wr(4'd2, 32'h1);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 4'd4;
    tick(); tick();
    prev = bus.readdata[0];
    n = 0;
    while (bus.readdata[0] === prev && n < 16) begin
      tick();
      n++;
    end
    chk("blink_toggle_seen", 32'(n < 16), 32'h1);
    lit = bus.readdata[0];
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 4 == 0) lit = ~lit;
      chk("blink_status", 32'(bus.readdata[0]), 32'(lit));
      chk("blink_digit0", 32'(out_port[6:0]), lit ? 32'h0E : 32'h7F);
      chk("blink_steady", 32'(out_port[20:7]), 32'h0436);
    end
    wr(4'd3, 32'h1);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 4'd4;
    tick(); tick();
    prev = bus.readdata[0];
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.readdata[0] !== prev) n++;
      prev = bus.readdata[0];
      chk("blank_digit0", 32'(out_port[6:0]), 32'h7F);
    end
    chk("blank_phase_toggles", n, 2);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    wr(4'd11, 32'h7F);
    wr(4'd4, 32'hFFFF);
    wr(4'd5, 32'hFFFF);
    for (int i = 0; i < 10; i++) begin
      rd(rd_addr[i]);
      chk($sformatf("regmap_%0d", rd_addr[i]), bus.readdata, rd_exp[i]);
    end
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 4'd0; bus.writedata = 32'h123;
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    chk("reset_wr_out0", 32'(out_port), 32'h102040);
    tick();
    chk("reset_wr_out1", 32'(out_port), 32'h102040);
    rd(4'd0);
    chk("reset_wr_data", bus.readdata, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
